piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in/serial-out front end for the 4-stage serial delay line (SISO4). Accepts WIDTH-bit words on a valid/ready handshake and emits them LSB-first, one bit per CLK, on a serial output that connects directly to the delay line's serial input `I`. It adds a per-bit valid strobe and a start-of-word marker, so downstream logic can realign words after the fixed 4-cycle line delay.

## Interface
- `WIDTH`, default 4: parallel word width in bits, ≥2.
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RESETN`  in  1: reset, asynchronous, active-low. Clears all state immediately.
- `CE`  in  1: clock enable. When low, all state holds.
- `I`  in  WIDTH: parallel word to serialize.
- `I_VALID`  in  1: `I` holds a valid word.
- `I_READY`  out  1: block accepts a word this cycle.
- `O`  out  1: serial data bit, LSB first.
- `O_VALID`  out  1: `O` carries a word bit this cycle.
- `SOF`  out  1: `O` carries bit 0 of a word.

## Operation
- State machine with two states:
  - IDLE: no word in flight.
  - SHIFT: word in flight; bit counter `cnt` runs 0..WIDTH-1.
- `I_READY = RESETN & CE & (state==IDLE | cnt==WIDTH-1)`.
  - Combinational from registered state, `CE` and `RESETN` only.
  - Never depends on `I_VALID`.
- Accept: `I_VALID & I_READY` at a rising edge.
  - Load `I` into the shift register `sr`.
  - Set `cnt=0` and go to SHIFT.
- In SHIFT with `CE=1`, each edge:
  - Shift `sr` right by one (zero fill).
  - Increment `cnt`.
- At `cnt==WIDTH-1` with `CE=1`:
  - Accept pending → reload `sr` and set `cnt=0`. Back-to-back words have no gap bit.
  - No accept pending → go to IDLE.
- Outputs:
  - `O = sr[0]` in SHIFT, 0 in IDLE.
  - `O_VALID = 1` in SHIFT.
  - `SOF = 1` in SHIFT when `cnt==0`.
- `CE=0`: `sr`, `cnt`, state and outputs all hold. `I_READY=0`, so no accept occurs.
- Words are never dropped or truncated, except by reset.

## Timing
- Reset values (`RESETN` low, asynchronous): state=IDLE, `cnt=0`, `sr=0`, `O=0`, `O_VALID=0`, `SOF=0`, `I_READY=0`.
- After `RESETN` deasserts, `I_READY=1` once `CE=1`.
- Latency: a word accepted at edge N drives bit 0 on `O` (with `SOF=1`) during the cycle after edge N. Bit k appears after edge N+k, for k=0..WIDTH-1.
- Throughput: one word per WIDTH cycles when `I_VALID` is held high.
- Reset mid-word: the partial word is discarded. No bits emit after reset release until a new accept.
- `I_VALID` dropping mid-word: no effect on the word in flight.
- End-to-end through SISO4: bit k of the word accepted at edge N appears at SISO4 `O` after edge N+k+4.

## Structure
- Shared package holds:
  - State enum: IDLE=1'b0, SHIFT=1'b1.
  - Counter-width function: `$clog2(WIDTH)`.
- Single module with no sub-modules. The serial datapath is a plain shift register, so it is coded inline.
- A top-level pairing `piso_serializer` with SISO4 lives in a separate integration file, not in this block.

## Test plan
- Reset and idle: hold `RESETN=0` for 3 cycles with `I_VALID=1`, `I=4'hF`.
  - `O=O_VALID=SOF=I_READY=0` throughout.
  - After release, `I_READY=1` and no output bits appear before an accept.
- Single word: `WIDTH=4`, `I=4'b1101` accepted at edge 0.
  - `O` = 1,0,1,1 after edges 0..3.
  - `SOF` high only after edge 0; `O_VALID` high for exactly 4 cycles, then 0.
- Back-to-back: words 4'hA then 4'h5 with `I_VALID` held high.
  - `I_READY` high on cycles 0 and 3.
  - `O` = 0,1,0,1,1,0,1,0 with no gap.
  - `SOF` high after edges 0 and 4.
- CE stall: drop `CE` for 2 cycles while `cnt=1`.
  - `O` and `cnt` hold; `I_READY=0`.
  - The remaining bits resume unchanged.
  - Total `O_VALID` cycles = 4 with `CE`-high counting.
- Reset mid-word: assert `RESETN=0` asynchronously (between clock edges) at `cnt=2`.
  - Outputs go to 0 immediately, before the next edge.
  - After release, the next accepted word 4'h3 emits 1,1,0,0 with `SOF` on bit 0.
- Integration with SISO4: send 4'b0110.
  - SISO4 `O` shows 0,1,1,0 starting 4 cycles after `SOF`.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out front end.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Serializes WIDTH-bit words LSB-first with per-bit valid and start-of-word
// marker, feeding the serial input of the 4-stage delay line.
//
// state | meaning
// IDLE  | no word in flight, outputs quiet
// SHIFT | word in flight, cnt selects the bit currently on O
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic             O,
  output logic             O_VALID,
  output logic             SOF
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             accept;

  // Ready on the last bit as well as in IDLE so back-to-back words have no gap.
  assign I_READY = RESETN & CE & ((state == IDLE) | (cnt == CNT_LAST));
  assign accept  = I_VALID & I_READY;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else if (CE) begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr    <= I;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == CNT_LAST) begin
            if (accept) begin
              sr  <= I;
              cnt <= '0;
            end else begin
              sr    <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end else begin
            sr  <= {1'b0, sr[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          sr    <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so they clear with the async reset.
  assign O       = (state == SHIFT) & sr[0];
  assign O_VALID = (state == SHIFT);
  assign SOF     = (state == SHIFT) & (cnt == '0);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with a small 4-stage delay line model.
module tb_piso_serializer;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       CE;
  logic [3:0] I;
  logic       I_VALID;
  logic       I_READY;
  logic       O;
  logic       O_VALID;
  logic       SOF;

  int total = 0;
  int bad   = 0;

  logic [3:0] siso;
  logic [3:0] w;
  int         vcnt;

  always #5 CLK = ~CLK;

  piso_serializer #(.WIDTH(4)) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .CE      (CE),
    .I       (I),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .O       (O),
    .O_VALID (O_VALID),
    .SOF     (SOF)
  );

  // Reference 4-stage serial delay line standing in for SISO4.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) siso <= '0;
    else if (CE) siso <= {siso[2:0], O};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN = 1'b0; CE = 1'b1; I_VALID = 1'b1; I = 4'hF;

    // reset and idle
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_outs", 32'({O, O_VALID, SOF, I_READY}), 32'd0);
    end
    I_VALID = 1'b0;
    RESETN = 1'b1;
    #1;
    chk("rel_ready", 32'(I_READY), 32'd1);
    tick();
    tick();
    chk("idle_no_bits", 32'({O, O_VALID, SOF}), 32'd0);

    // single word 1101
    w = 4'b1101; I = w; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("single_o", 32'(O), 32'(w[k]));
      chk("single_ov", 32'(O_VALID), 32'd1);
      chk("single_sof", 32'(SOF), 32'(k == 0));
      chk("single_rdy", 32'(I_READY), 32'(k == 3));
      tick();
    end
    chk("single_end", 32'({O, O_VALID, SOF}), 32'd0);

    // back-to-back A then 5
    I = 4'hA; I_VALID = 1'b1;
    #1;
    chk("b2b_rdy0", 32'(I_READY), 32'd1);
    tick();
    I = 4'h5;
    begin
      logic [7:0] seq;
      seq = 8'b0101_1010; // bits in emission order, index 0 first
      for (int k = 0; k < 8; k++) begin
        chk("b2b_o", 32'(O), 32'(seq[k]));
        chk("b2b_ov", 32'(O_VALID), 32'd1);
        chk("b2b_sof", 32'(SOF), 32'(k == 0 || k == 4));
        chk("b2b_rdy", 32'(I_READY), 32'(k == 3 || k == 7));
        if (k == 4) I_VALID = 1'b0;
        tick();
      end
    end
    chk("b2b_end", 32'(O_VALID), 32'd0);

    // CE stall at cnt=1, word 0101 -> bits 1,0,1,0
    vcnt = 0;
    w = 4'b0101; I = w; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    chk("ce_b0", 32'({O, SOF}), 32'b11);
    if (O_VALID && CE) vcnt++;
    tick();
    chk("ce_b1", 32'({O, SOF}), 32'b00);
    if (O_VALID && CE) vcnt++;
    CE = 1'b0;
    I_VALID = 1'b1;
    #1;
    chk("ce_rdy_low", 32'(I_READY), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("ce_hold", 32'({O, O_VALID, SOF, I_READY}), 32'b0100);
    end
    I_VALID = 1'b0;
    CE = 1'b1;
    tick();
    chk("ce_b2", 32'({O, O_VALID}), 32'b11);
    if (O_VALID && CE) vcnt++;
    tick();
    chk("ce_b3", 32'({O, O_VALID}), 32'b01);
    if (O_VALID && CE) vcnt++;
    tick();
    if (O_VALID && CE) vcnt++;
    chk("ce_ov_count", 32'(vcnt), 32'd4);

    // reset mid-word, word C -> bits 0,0,1,1 ; cnt=2 shows O=1
    I = 4'hC; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    tick();
    tick();
    chk("mid_pre", 32'({O, O_VALID}), 32'b11);
    #2;
    RESETN = 1'b0;
    #1;
    chk("mid_async", 32'({O, O_VALID, SOF, I_READY}), 32'd0);
    tick();
    RESETN = 1'b1;
    tick();
    chk("mid_quiet", 32'({O, O_VALID, SOF}), 32'd0);
    w = 4'h3; I = w; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("mid_word", 32'({O, O_VALID, SOF}), 32'({w[k], 1'b1, (k == 0)}));
      tick();
    end

    // integration through the 4-stage delay line
    w = 4'b0110; I = w; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    chk("int_sof", 32'(SOF), 32'd1);
    for (int t = 1; t < 8; t++) begin
      tick();
      if (t >= 4) chk("int_siso", 32'(siso[3]), 32'(w[t-4]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
